cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL declare clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL declare rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL declare en  input  1  instruction-valid/advance; 0 = stall, no state change.
REQ-004 SHALL declare cond  input  4  instruction condition field, Instr[31:28].
REQ-005 SHALL declare alu_flags  input  4  ALU result flags {N,Z,C,V}, bit3=N.
REQ-006 SHALL declare flag_write  input  2  decoder flag enables; [1]=N/Z group, [0]=C/V group.
REQ-007 SHALL declare pc_src, reg_write, mem_write, no_write  input  1 each  unconditional decoder controls.
REQ-008 SHALL declare pc_src_c, reg_write_c, mem_write_c  output  1 each  condition-qualified controls.
REQ-009 SHALL declare cond_ex  output  1  condition passed for current instruction.
REQ-010 SHALL declare flags  output  4  architectural {N,Z,C,V} register.
REQ-011 SHALL declare exec_cnt, skip_cnt  output  16 each  executed / squashed instruction counters.

Function
REQ-012 cond_ex SHALL be combinational from cond and the registered flags (pre-update value), same cycle.
REQ-013 Condition map SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F SHALL evaluate to 1.
REQ-014 pc_src_c SHALL equal pc_src & cond_ex & en.
REQ-015 reg_write_c SHALL equal reg_write & !no_write & cond_ex & en.
REQ-016 mem_write_c SHALL equal mem_write & cond_ex & en.
REQ-017 On a clock edge with en=1, cond_ex=1, flag_write[1]=1: flags[3:2] SHALL load alu_flags[3:2].
REQ-018 On a clock edge with en=1, cond_ex=1, flag_write[0]=1: flags[1:0] SHALL load alu_flags[1:0].
REQ-019 Groups SHALL update independently; an unset group SHALL hold its value.
REQ-020 When cond_ex=0 or en=0, flags SHALL hold regardless of flag_write.
REQ-021 Flag update latency SHALL be one cycle: the next instruction's cond_ex sees the new flags.
REQ-022 On edge with en=1: exec_cnt SHALL increment if cond_ex=1, else skip_cnt SHALL increment; exactly one increments.
REQ-023 Counters SHALL wrap modulo 2^16 (0xFFFF -> 0x0000), no saturation or sticky flag.
REQ-024 en=0 SHALL freeze both counters and flags; all *_c outputs SHALL be 0.

Reset
REQ-025 rst=1 at a rising edge SHALL set flags=4'b0000, exec_cnt=0, skip_cnt=0.
REQ-026 rst SHALL take priority over en and flag_write in the same cycle; update in progress is discarded.
REQ-027 During reset, *_c outputs SHALL follow REQ-014..016 combinationally using flags=0 (so EQ fails, NE passes).

Structure
REQ-028 A shared package cond_pkg SHALL hold the cond_e enum (EQ..AL, 4 bits) and flag bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
REQ-029 Condition evaluation SHALL be a combinational sub-module cond_check (inputs cond, flags; output cond_ex); cond_unit holds registers, gating and counters.
REQ-030 Flag register SHALL be two 2-bit registers with separate enables, no latches.

Verification
REQ-031 Reset then cond=E, alu_flags=4'b0100, flag_write=2'b11, en=1 -> next cycle flags=4'b0100, exec_cnt=1.
REQ-032 flags=4'b0100 (Z), cond=1 (NE), reg_write=1, pc_src=1, flag_write=2'b11, alu_flags=4'b1011 -> cond_ex=0, reg_write_c=0, pc_src_c=0, flags stay 4'b0100, skip_cnt+1.
REQ-033 flags=0, cond=E, flag_write=2'b10, alu_flags=4'b1111 -> flags=4'b1100 (C/V held).
REQ-034 Compare op: cond=E, reg_write=1, no_write=1, flag_write=2'b11 -> reg_write_c=0, flags updated.
REQ-035 exec_cnt=0xFFFF, one AL instruction, en=1 -> exec_cnt=0x0000; then en=0 with flag_write=2'b11 -> flags, counters unchanged, all *_c=0.
REQ-036 Sweep all 16 cond against all 16 flag values -> cond_ex matches REQ-013 table; rst asserted mid-sequence with flag_write=2'b11 -> flags=0 next cycle.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: shared condition-code enum and {N,Z,C,V} flag bit positions.
//   cond_e  : 4-bit condition field encodings EQ..AL (15 is unnamed, treated as always)
//   *_BIT   : bit index of each flag inside the 4-bit flag vector
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder-to-condition-unit bundle.
//   master drives : en, cond, alu_flags, flag_write, pc_src, reg_write, mem_write, no_write
//   slave drives  : pc_src_c, reg_write_c, mem_write_c, cond_ex, flags, exec_cnt, skip_cnt
interface cond_unit_if;

    logic        en;
    logic [3:0]  cond;
    logic [3:0]  alu_flags;
    logic [1:0]  flag_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_write;
    logic        no_write;
    logic        pc_src_c;
    logic        reg_write_c;
    logic        mem_write_c;
    logic        cond_ex;
    logic [3:0]  flags;
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;

    modport master (
        output en, cond, alu_flags, flag_write, pc_src, reg_write, mem_write, no_write,
        input  pc_src_c, reg_write_c, mem_write_c, cond_ex, flags, exec_cnt, skip_cnt
    );

    modport slave (
        input  en, cond, alu_flags, flag_write, pc_src, reg_write, mem_write, no_write,
        output pc_src_c, reg_write_c, mem_write_c, cond_ex, flags, exec_cnt, skip_cnt
    );

endinterface

// File: rtl/cond_check.sv
// cond_check: combinational condition evaluation.
//   cond    : instruction condition field
//   flags   : architectural {N,Z,C,V}
//   cond_ex : 1 when the instruction's condition holds
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    always_comb begin
        n = flags[N_BIT];
        z = flags[Z_BIT];
        c = flags[C_BIT];
        v = flags[V_BIT];
        case (cond_e'(cond))
            EQ:      cond_ex = z;
            NE:      cond_ex = !z;
            CS:      cond_ex = c;
            CC:      cond_ex = !c;
            MI:      cond_ex = n;
            PL:      cond_ex = !n;
            VS:      cond_ex = v;
            VC:      cond_ex = !v;
            HI:      cond_ex = c & !z;
            LS:      cond_ex = !c | z;
            GE:      cond_ex = n == v;
            LT:      cond_ex = n != v;
            GT:      cond_ex = !z & (n == v);
            LE:      cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution unit with flag register and exec/skip counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cond_unit_if.slave (decoder controls in, qualified controls/flags/counters out)
module cond_unit
    import cond_pkg::*;
(
    input logic        clk,
    input logic        rst,
    cond_unit_if.slave bus
);

    logic [1:0]  nz_q, nz_d, cv_q, cv_d;
    logic [15:0] exec_cnt_q, exec_cnt_d, skip_cnt_q, skip_cnt_d;
    logic        cond_ex, go;

    // Evaluated against the registered flags, so an instruction never sees its own update.
    cond_check u_check (
        .cond    (bus.cond),
        .flags   ({nz_q, cv_q}),
        .cond_ex (cond_ex)
    );

    always_comb begin
        go         = bus.en & cond_ex;
        nz_d       = (go & bus.flag_write[1]) ? bus.alu_flags[N_BIT:Z_BIT] : nz_q;
        cv_d       = (go & bus.flag_write[0]) ? bus.alu_flags[C_BIT:V_BIT] : cv_q;
        exec_cnt_d = exec_cnt_q + 16'(go);
        skip_cnt_d = skip_cnt_q + 16'(bus.en & !cond_ex);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nz_q       <= '0;
            cv_q       <= '0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            nz_q       <= nz_d;
            cv_q       <= cv_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign bus.cond_ex     = cond_ex;
    assign bus.pc_src_c    = bus.pc_src & go;
    assign bus.reg_write_c = bus.reg_write & !bus.no_write & go;
    assign bus.mem_write_c = bus.mem_write & go;
    assign bus.flags       = {nz_q, cv_q};
    assign bus.exec_cnt    = exec_cnt_q;
    assign bus.skip_cnt    = skip_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: self-checking bench for cond_unit against a behavioural model.
module tb_cond_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    cond_unit_if bus ();

    cond_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] mf;
    int         me, ms;
    bit         mv = 1'b0;

    // Conditions come in pairs: even code tests a predicate, odd code its negation.
    function automatic bit ref_cond(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mf = 4'b0; me = 0; ms = 0; mv = 1'b1;
        end else if (mv && bus.en) begin
            if (ref_cond(bus.cond, mf)) begin
                me++;
                if (bus.flag_write[1]) mf[3:2] = bus.alu_flags[3:2];
                if (bus.flag_write[0]) mf[1:0] = bus.alu_flags[1:0];
            end else begin
                ms++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit ce;
        if (mv) begin
            ce = ref_cond(bus.cond, mf);
            chk("cond_ex", 16'(bus.cond_ex), 16'(ce));
            chk("pc_src_c", 16'(bus.pc_src_c), 16'(bus.pc_src && ce && bus.en));
            chk("reg_write_c", 16'(bus.reg_write_c), 16'(bus.reg_write && !bus.no_write && ce && bus.en));
            chk("mem_write_c", 16'(bus.mem_write_c), 16'(bus.mem_write && ce && bus.en));
            chk("flags", 16'(bus.flags), 16'(mf));
            chk("exec_cnt", bus.exec_cnt, 16'(me % 65536));
            chk("skip_cnt", bus.skip_cnt, 16'(ms % 65536));
        end
    end

    task automatic drv(logic e, logic [3:0] c, logic [3:0] a, logic [1:0] fw,
                       logic pc, logic rw, logic mw, logic nw);
        bus.en = e; bus.cond = c; bus.alu_flags = a; bus.flag_write = fw;
        bus.pc_src = pc; bus.reg_write = rw; bus.mem_write = mw; bus.no_write = nw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
        step();
        step();
        chk("rst_flags", 16'(bus.flags), 16'h0);
        chk("rst_exec", bus.exec_cnt, 16'h0);
        chk("rst_skip", bus.skip_cnt, 16'h0);
        bus.cond = 4'h0;
        #1 chk("rst_eq_pc_c", 16'(bus.pc_src_c), 16'h0);
        bus.cond = 4'h1;
        #1 chk("rst_ne_pc_c", 16'(bus.pc_src_c), 16'h1);

        rst = 1'b0;
        drv(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        step();
        chk("al_flags", 16'(bus.flags), 16'h4);
        chk("al_exec", bus.exec_cnt, 16'h1);

        drv(1, 4'h1, 4'b1011, 2'b11, 1, 1, 0, 0);
        #1;
        chk("ne_cond_ex", 16'(bus.cond_ex), 16'h0);
        chk("ne_rw_c", 16'(bus.reg_write_c), 16'h0);
        chk("ne_pc_c", 16'(bus.pc_src_c), 16'h0);
        step();
        chk("ne_flags", 16'(bus.flags), 16'h4);
        chk("ne_skip", bus.skip_cnt, 16'h1);

        drv(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0);
        step();
        drv(1, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0);
        step();
        chk("nz_only_flags", 16'(bus.flags), 16'hC);

        drv(1, 4'hE, 4'b0011, 2'b11, 0, 1, 0, 1);
        #1 chk("cmp_rw_c", 16'(bus.reg_write_c), 16'h0);
        step();
        chk("cmp_flags", 16'(bus.flags), 16'h3);

        drv(1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 65531; i++) step();
        chk("exec_max", bus.exec_cnt, 16'hFFFF);
        step();
        chk("exec_wrap", bus.exec_cnt, 16'h0000);
        drv(0, 4'hE, 4'b1100, 2'b11, 1, 1, 1, 0);
        #1;
        chk("stall_pc_c", 16'(bus.pc_src_c), 16'h0);
        chk("stall_rw_c", 16'(bus.reg_write_c), 16'h0);
        chk("stall_mw_c", 16'(bus.mem_write_c), 16'h0);
        step();
        step();
        chk("stall_flags", 16'(bus.flags), 16'h3);
        chk("stall_exec", bus.exec_cnt, 16'h0);
        chk("stall_skip", bus.skip_cnt, 16'h1);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drv($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        rst = 1'b0;

        for (int f = 0; f < 16; f++) begin
            drv(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
            step();
            chk("sweep_load", 16'(bus.flags), 16'(f));
            for (int c = 0; c < 16; c++) begin
                drv(0, 4'(c), 4'($urandom), 2'b11, 1, 1, 1, 0);
                step();
            end
        end

        drv(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        step();
        chk("pre_rst_flags", 16'(bus.flags), 16'hF);
        rst = 1'b1;
        step();
        chk("mid_rst_flags", 16'(bus.flags), 16'h0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
